// File: rtl/modular_subtractor.sv
// Limb-serial 256-bit modular subtractor: result = (A - B) mod P, one limb per clock.
// Define MODSUB_OPERAND_PORTS_EN to take operands from i_a/i_b instead of OPERAND_A/OPERAND_B.
module modular_subtractor #(
  parameter int           LIMB_W    = 32,
  parameter logic [255:0] P         = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
  parameter logic [255:0] OPERAND_A = 256'h0,
  parameter logic [255:0] OPERAND_B = 256'h86419981_06234453_aa5f9d6a_3178f4f8_fd640324_d231d723_62ca3b61_a5c4a524
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
`ifdef MODSUB_OPERAND_PORTS_EN
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
`endif
  output logic [255:0] result,
  output logic         done
);

  localparam int         N    = 256 / LIMB_W;
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

  state_t          state, next;
  logic [255:0]    a_reg, b_reg;
  logic [255:0]    op_a, op_b;
  logic [3:0]      idx;
  logic            cy;
  logic [7:0]      base;
  logic            last;
  logic [LIMB_W:0] diff, sum;

`ifdef MODSUB_OPERAND_PORTS_EN
  assign op_a = i_a;
  assign op_b = i_b;
`else
  assign op_a = OPERAND_A;
  assign op_b = OPERAND_B;
`endif

  // cy is the borrow during SUB and the carry during CORR
  always_comb begin
    base = 8'(idx * LIMB_W);
    last = (idx == LAST);
    diff = {1'b0, a_reg[base +: LIMB_W]} - {1'b0, b_reg[base +: LIMB_W]}
         - {{LIMB_W{1'b0}}, cy};
    sum  = {1'b0, result[base +: LIMB_W]} + {1'b0, P[base +: LIMB_W]}
         + {{LIMB_W{1'b0}}, cy};
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (i_start) next = SUB;
      SUB:  if (last) next = diff[LIMB_W] ? CORR : DONE;
      CORR: if (last) next = DONE;
      DONE: if (!i_start) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      done   <= 1'b0;
      idx    <= '0;
      cy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a_reg <= op_a;
            b_reg <= op_b;
            idx   <= '0;
            cy    <= 1'b0;
            done  <= 1'b0;
          end
        end
        SUB: begin
          result[base +: LIMB_W] <= diff[LIMB_W-1:0];
          idx <= last ? '0 : idx + 4'd1;
          cy  <= last ? 1'b0 : diff[LIMB_W];
          if (last && !diff[LIMB_W]) done <= 1'b1;
        end
        CORR: begin
          // carry out of the top limb is dropped: the sum wraps mod 2^256
          result[base +: LIMB_W] <= sum[LIMB_W-1:0];
          idx <= last ? '0 : idx + 4'd1;
          cy  <= last ? 1'b0 : sum[LIMB_W];
          if (last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_subtractor.sv
// Scoreboard bench for modular_subtractor: several parameterisations run side by side,
// expected results and completion edges queued at launch and checked on each done rise.
module tb_modular_subtractor;

  localparam logic [255:0] PM   = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] PM1  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
  localparam logic [255:0] PM2  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;
  localparam logic [255:0] BDEF = 256'h86419981_06234453_aa5f9d6a_3178f4f8_fd640324_d231d723_62ca3b61_a5c4a524;
  localparam logic [255:0] GX   = 256'h79be667e_f9dcbbac_55a06295_ce870b07_029bfcdb_2dce28dc_9d35c49d_5a3b570b;

`ifdef MODSUB_OPERAND_PORTS_EN
  localparam int NI = 6;
`else
  localparam int NI = 5;
`endif

  typedef struct {
    logic [255:0] res;
    int unsigned  edge_no;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st  [NI];
  logic [255:0] res [NI];
  logic         dn  [NI];
  logic         prev[NI];

  logic [255:0] exp_res[NI];
  int unsigned  exp_lat[NI];
  exp_t         exp_q[NI][$];

  int unsigned  edges    = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  modular_subtractor #(.LIMB_W(32)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]),
`ifdef MODSUB_OPERAND_PORTS_EN
    .i_a(256'h0), .i_b(BDEF),
`endif
    .result(res[0]), .done(dn[0]));

  modular_subtractor #(.LIMB_W(32), .OPERAND_A(256'd5), .OPERAND_B(256'd3)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]),
`ifdef MODSUB_OPERAND_PORTS_EN
    .i_a(256'd5), .i_b(256'd3),
`endif
    .result(res[1]), .done(dn[1]));

  modular_subtractor #(.LIMB_W(32), .OPERAND_A(256'd3), .OPERAND_B(256'd5)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(st[2]),
`ifdef MODSUB_OPERAND_PORTS_EN
    .i_a(256'd3), .i_b(256'd5),
`endif
    .result(res[2]), .done(dn[2]));

  modular_subtractor #(.LIMB_W(32), .OPERAND_A(PM1), .OPERAND_B(PM1)) u3 (
    .i_clk(clk), .i_rst(rst), .i_start(st[3]),
`ifdef MODSUB_OPERAND_PORTS_EN
    .i_a(PM1), .i_b(PM1),
`endif
    .result(res[3]), .done(dn[3]));

  modular_subtractor #(.LIMB_W(64), .OPERAND_A(256'd3), .OPERAND_B(256'd5)) u4 (
    .i_clk(clk), .i_rst(rst), .i_start(st[4]),
`ifdef MODSUB_OPERAND_PORTS_EN
    .i_a(256'd3), .i_b(256'd5),
`endif
    .result(res[4]), .done(dn[4]));

`ifdef MODSUB_OPERAND_PORTS_EN
  modular_subtractor #(.LIMB_W(32)) u5 (
    .i_clk(clk), .i_rst(rst), .i_start(st[5]),
    .i_a(256'd10), .i_b(256'd4),
    .result(res[5]), .done(dn[5]));
`endif

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Called just after a negedge: the next posedge is the accepting edge.
  task automatic launch(input int i);
    exp_t e;
    e.res     = exp_res[i];
    e.edge_no = edges + 1 + exp_lat[i];
    exp_q[i].push_back(e);
    st[i] = 1'b1;
  endtask

  task automatic wait_all();
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 60 && !empty; c++) begin
      @(posedge clk);
      #2;
      empty = 1'b1;
      for (int i = 0; i < NI; i++) if (exp_q[i].size() != 0) empty = 1'b0;
    end
    n_checks++;
    if (!empty) begin
      n_fail++;
      $display("FAIL completion_timeout: got pending results expected none pending");
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dn[i] === 1'b1 && prev[i] !== 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done u%0d: got done rise expected none", i);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          check($sformatf("result_u%0d", i), res[i], e.res);
          check($sformatf("latency_edge_u%0d", i), 256'(edges), 256'(e.edge_no));
        end
      end
      prev[i] = dn[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    exp_res[0] = GX;      exp_lat[0] = 16;
    exp_res[1] = 256'd2;  exp_lat[1] = 8;
    exp_res[2] = PM2;     exp_lat[2] = 16;
    exp_res[3] = 256'd0;  exp_lat[3] = 8;
    exp_res[4] = PM2;     exp_lat[4] = 8;
`ifdef MODSUB_OPERAND_PORTS_EN
    exp_res[5] = 256'd6;  exp_lat[5] = 8;
`endif

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_result_u%0d", i), res[i], 256'd0);
      check($sformatf("reset_done_u%0d", i), 256'(dn[i]), 256'd0);
    end
    rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < NI; i++) launch(i);
    wait_all();

    // start stays high: nothing may retrigger, outputs must hold
    while ($time < 1000) @(negedge clk);
    check("hold_result_u0", res[0], GX);
    check("hold_done_u0", 256'(dn[0]), 256'd1);
    check("hold_result_u2", res[2], PM2);

    st[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done_u3", 256'(dn[3]), 256'd1);
    launch(3);
    @(posedge clk);
    #1;
    check("restart_done_low_u3", 256'(dn[3]), 256'd0);
    wait_all();

    st[2] = 1'b0;
    repeat (2) @(negedge clk);
    st[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("midop_reset_result_u%0d", i), res[i], 256'd0);
      check($sformatf("midop_reset_done_u%0d", i), 256'(dn[i]), 256'd0);
    end
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) launch(i);
    wait_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
